mult32_seq_ctrl: RTL and testbench

Sequential 32×32 multiplier controller that produces a 64-bit product over 34 clocks using a single 32-bit add/shift step per cycle. It replaces the fully unrolled array multiplier where area matters. It also sequences operand sign conversion, the iterative accumulate/shift, and final result negation. It sits beside the ALU and hands {HI, LO} to the register file through a START/BUSY/DONE handshake.

---
 rtl/mult32_seq_ctrl.sv | 116 +++++++++++
 tb/tb_mult32_seq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mult32_seq_ctrl.sv
// Sequential 32x32 multiplier: sign-magnitude operands, one add/shift step per clock,
// final negation, and a START/BUSY/DONE handshake that delivers {hi, lo}.
module mult32_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  cnt_r;
  logic [63:0] p_r;
  logic [31:0] m_r;
  logic        sign_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic [32:0] sum_s;
  logic [63:0] neg_s;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign sum_s = {1'b0, p_r[63:32]} + {1'b0, (p_r[0] ? m_r : 32'd0)};
  assign neg_s = ~p_r + 64'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a START in DONE chains straight into RUN.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_r == 5'd31) state_s = ST_FIX;
        else                state_s = ST_RUN;
      end
      ST_FIX:  state_s = ST_DONE;
      ST_DONE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 5'd0;
      p_r    <= 64'd0;
      m_r    <= 32'd0;
      sign_r <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_RUN) || (state_s == ST_FIX);
      done_r <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            m_r    <= mag(a, signed_op & a[31]);
            p_r    <= {32'd0, mag(b, signed_op & b[31])};
            sign_r <= signed_op & (a[31] ^ b[31]);
            cnt_r  <= 5'd0;
          end
        end
        ST_RUN: begin
          p_r   <= {sum_s, p_r[31:1]};
          cnt_r <= cnt_r + 5'd1;
        end
        ST_FIX: begin
          {hi_r, lo_r} <= sign_r ? neg_s : p_r;
        end
        default: begin
          cnt_r <= 5'd0;
        end
      endcase
    end
  end

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Scoreboard bench for mult32_seq_ctrl: driver pushes reference products, monitor
// pops on every DONE; also checks latency, busy length, reset and output hold.
module tb_mult32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  mult32_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(sgn),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = s ? {{32{x[31]}}, x} : {32'd0, x};
    ey = s ? {{32{y[31]}}, y} : {32'd0, y};
    return ex * ey;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // Monitor: pop on DONE, check outputs hold otherwise, and busy/done exclusivity.
  initial begin : monitor
    logic [63:0] prev;
    logic        prev_ok;
    logic [63:0] e;
    prev_ok = 1'b0;
    prev = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ok = 1'b0;
      end else begin
        chk("busy_and_done", {63'd0, busy & done}, 64'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("product", {hi, lo}, e);
          end
        end else if (prev_ok) begin
          chk("hold", {hi, lo}, prev);
        end
        prev = {hi, lo};
        prev_ok = 1'b1;
      end
    end
  end

  // Issue one operation from a negedge with busy low; returns DONE latency and busy length.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input int ign_at, output int lat, output int bcnt);
    int w;
    w = 0;
    while (busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
    a = ta; b = tb; sgn = ts; start = 1'b1;
    exp_q.push_back(model(ta, tb, ts));
    @(posedge clk);
    lat = 0;
    bcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (lat == ign_at) begin
        start = 1'b1; a = 32'd2; b = 32'd2; sgn = 1'b0;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom; sgn = 1'($urandom);
      end
      if (busy) bcnt++;
      if (done) break;
      lat++;
    end
    if (!done) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin : driver
    int lat;
    int bc;
    int c1;
    int w;
    logic [31:0] ra;
    logic [31:0] rb;

    #2;
    chk("reset_out", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, lat, bc);
    chk("latency_ucorner", 64'(lat), 64'd33);
    chk("busy_len_ucorner", 64'(bc), 64'd33);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);

    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, -1, lat, bc);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, lat, bc);
    run_op(32'd0, 32'hFFFF_FFFB, 1'b1, -1, lat, bc);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, lat, bc);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, -1, lat, bc);
    run_op(32'h8000_0000, 32'h0000_0003, 1'b1, -1, lat, bc);

    // START pulsed mid-operation must be ignored.
    run_op(32'd6, 32'd7, 1'b0, 4, lat, bc);
    chk("latency_ignore", 64'(lat), 64'd33);

    // Back-to-back: START held in the DONE cycle.
    c1 = cyc;
    run_op(32'd9, 32'd9, 1'b0, -1, lat, bc);
    chk("b2b_gap", 64'(cyc - c1), 64'd34);

    // Reset in the middle of a run (operation is not scoreboarded).
    @(negedge clk);
    a = 32'd5; b = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset_out", {hi, lo}, 64'd0);
    chk("midrun_reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd3, 32'd4, 1'b0, -1, lat, bc);
    chk("latency_after_reset", 64'(lat), 64'd33);

    // Random regression, mixing back-to-back and idle gaps.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 15);
        default: ra = $urandom;
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(ra, rb, 1'($urandom), -1, lat, bc);
      if (lat != 33) chk("latency_random", 64'(lat), 64'd33);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
